// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, RV32 opcode/funct fields,
// decode classes and ALU select codes.
`default_nettype none

package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_ILLEGAL = 2'd0,
        CLS_ADD     = 2'd1,
        CLS_ADDI    = 2'd2
    } cls_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [1:0] ALU_ADD   = 2'b00;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: recognises add and addi, everything else is illegal.
`default_nettype none

module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output cls_t        cls,
    output logic        bsel,
    output logic [1:0]  alu_sel,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register specifiers and the immediate body play no part in classification.
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        cls     = CLS_ILLEGAL;
        bsel    = 1'b0;
        alu_sel = ALU_ADD;
        if (opcode == OPC_OP && funct3 == F3_ADD && funct7 == F7_ADD) begin
            cls = CLS_ADD;
        end else if (opcode == OPC_OPIMM && funct3 == F3_ADD) begin
            cls  = CLS_ADDI;
            bsel = 1'b1;
        end
    end

    assign legal = (cls != CLS_ILLEGAL);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/WB controller with fetch timeout, sticky fault flags
// and a retired-instruction counter.
`default_nettype none

module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] instr,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_write,
    output logic        bsel,
    output logic [1:0]  alu_sel,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        timeout,
    output logic [31:0] retired
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(IMEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_inc;
    logic [31:0] ir_q, retired_q;
    logic        illegal_q, timeout_q;
    cls_t        cls_q;
    logic        bsel_q;
    logic [1:0]  alu_q;
    logic        wb_fire, exec_or_wb;

    cls_t        dec_cls;
    logic        dec_bsel, dec_legal;
    logic [1:0]  dec_alu_sel;

    ctrl_decode u_decode (
        .instr   (ir_q),
        .cls     (dec_cls),
        .bsel    (dec_bsel),
        .alu_sel (dec_alu_sel),
        .legal   (dec_legal)
    );

    assign wait_inc   = wait_q + 8'd1;
    assign exec_or_wb = (state_q == ST_EXEC) || (state_q == ST_WB);
    assign wb_fire    = (state_q == ST_WB) && (cls_q != CLS_ILLEGAL);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                // A ready on the final allowed cycle still counts as a fetch.
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_inc == TIMEOUT_CNT) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_FAULT;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = run ? ST_FETCH : ST_IDLE;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_FAULT;
        endcase
    end

    assign reg_write = wb_fire;
    assign pc_we     = wb_fire;
    assign bsel      = exec_or_wb ? bsel_q : 1'b0;
    assign alu_sel   = exec_or_wb ? alu_q  : 2'b00;
    assign state     = state_q;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign retired   = retired_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= 8'd0;
            retired_q <= 32'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            ir_q      <= 32'd0;
            cls_q     <= CLS_ILLEGAL;
            bsel_q    <= 1'b0;
            alu_q     <= ALU_ADD;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH) begin
                if (imem_ready) begin
                    ir_q   <= instr;
                    wait_q <= 8'd0;
                end else begin
                    wait_q <= wait_inc;
                    if (wait_inc == TIMEOUT_CNT) timeout_q <= 1'b1;
                end
            end
            if (state_q == ST_DECODE) begin
                if (dec_legal) begin
                    cls_q  <= dec_cls;
                    bsel_q <= dec_bsel;
                    alu_q  <= dec_alu_sel;
                end else begin
                    illegal_q <= 1'b1;
                end
            end
            if (wb_fire) retired_q <= retired_q + 32'd1;
        end
    end

endmodule

`default_nettype wire
